// File: rtl/sigmoid_sched_pkg.sv
// rtl/sigmoid_sched_pkg.sv - shared widths and grant helpers for the sigmoid round-robin scheduler
package sigmoid_sched_pkg;

    localparam int X_W     = 8;
    localparam int Y_W     = 16;
    localparam int CNT_W   = 16;
    localparam int MAX_REQ = 8;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] id);
        logic [MAX_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Returns {found, id}: first valid requester at or after ptr, wrapping at nreq.
    function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0]         ptr,
                                           input logic [3:0]         nreq);
        logic [3:0] pick;
        logic [3:0] idx;
        pick = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= nreq) begin
                idx = idx - nreq;
            end
            if ((4'(k) < nreq) && valid[idx[2:0]]) begin
                pick = {1'b1, idx[2:0]};
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sigmoid_tag_pipe.sv
// rtl/sigmoid_tag_pipe.sv - valid+id delay line matched to the sigmoid pipeline depth
module sigmoid_tag_pipe #(
    parameter int LATENCY = 3,
    parameter int IDW     = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [IDW-1:0] in_id,
    output logic           out_valid,
    output logic [IDW-1:0] out_id
);

    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] vld_d;
    logic [IDW-1:0]     id_q [LATENCY];
    logic [IDW-1:0]     id_d [LATENCY];

    always_comb begin
        vld_d    = '0;
        vld_d[0] = in_valid;
        id_d[0]  = in_id;
        for (int k = 1; k < LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
            id_d[k]  = id_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                id_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < LATENCY; k++) begin
                id_q[k] <= id_d[k];
            end
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign out_id    = id_q[LATENCY-1];

endmodule

// File: rtl/sigmoid_rr_sched.sv
// rtl/sigmoid_rr_sched.sv - round-robin scheduler sharing one pipelined sigmoid among NREQ requesters
module sigmoid_rr_sched
    import sigmoid_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int LATENCY = 3,
    parameter int IDW     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_hold,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*X_W-1:0] req_x,
    output logic [NREQ-1:0]     req_ready,
    output logic [X_W-1:0]      sig_x,
    output logic                sig_in_valid,
    input  logic                sig_out_valid,
    input  logic [Y_W-1:0]      sig_y,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [Y_W-1:0]      rsp_y,
    output logic [CNT_W-1:0]    issued_cnt,
    output logic                o_err
);

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [X_W-1:0]   sig_x_q, sig_x_d;
    logic             sig_in_valid_q, sig_in_valid_d;
    logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [Y_W-1:0]   rsp_y_q, rsp_y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [3:0]       pick;
    logic [IDW-1:0]   grant_id;
    logic             hs;
    logic             tag_valid;
    logic [IDW-1:0]   tag_id;
    logic             ret;

    always_comb begin
        pick      = rr_pick(MAX_REQ'(req_valid), 3'(ptr_q), 4'(NREQ));
        hs        = pick[3] & ~i_hold;
        grant_id  = pick[IDW-1:0];
        req_ready = hs ? NREQ'(onehot(pick[2:0])) : '0;

        sig_in_valid_d = hs;
        sig_x_d        = hs ? req_x[grant_id*X_W +: X_W] : sig_x_q;
        id_d           = hs ? grant_id : id_q;
        ptr_d          = ptr_q;
        if (hs) begin
            ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(hs);

        // A tag without a result, or a result without a tag, means the pipe depths disagree.
        ret         = tag_valid & sig_out_valid;
        rsp_valid_d = ret ? NREQ'(onehot(3'(tag_id))) : '0;
        rsp_y_d     = ret ? sig_y : rsp_y_q;
        err_d       = err_q | (tag_valid ^ sig_out_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q          <= '0;
            id_q           <= '0;
            sig_x_q        <= '0;
            sig_in_valid_q <= 1'b0;
            rsp_valid_q    <= '0;
            rsp_y_q        <= '0;
            cnt_q          <= '0;
            err_q          <= 1'b0;
        end else begin
            ptr_q          <= ptr_d;
            id_q           <= id_d;
            sig_x_q        <= sig_x_d;
            sig_in_valid_q <= sig_in_valid_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_y_q        <= rsp_y_d;
            cnt_q          <= cnt_d;
            err_q          <= err_d;
        end
    end

    sigmoid_tag_pipe #(
        .LATENCY (LATENCY),
        .IDW     (IDW)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (sig_in_valid_q),
        .in_id     (id_q),
        .out_valid (tag_valid),
        .out_id    (tag_id)
    );

    assign sig_x        = sig_x_q;
    assign sig_in_valid = sig_in_valid_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_y        = rsp_y_q;
    assign issued_cnt   = cnt_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_sigmoid_rr_sched.sv
// tb/tb_sigmoid_rr_sched.sv - scoreboard bench for sigmoid_rr_sched with a behavioural sigmoid
module tb_sigmoid_rr_sched;

    localparam int NREQ = 4;
    localparam int L    = 3;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_hold;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_x;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        sig_x;
    logic              sig_in_valid;
    logic              sig_out_valid;
    logic [15:0]       sig_y;
    logic [NREQ-1:0]   rsp_valid;
    logic [15:0]       rsp_y;
    logic [15:0]       issued_cnt;
    logic              o_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    sigmoid_rr_sched #(.NREQ(NREQ), .LATENCY(L), .IDW(IDW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_hold        (i_hold),
        .req_valid     (req_valid),
        .req_x         (req_x),
        .req_ready     (req_ready),
        .sig_x         (sig_x),
        .sig_in_valid  (sig_in_valid),
        .sig_out_valid (sig_out_valid),
        .sig_y         (sig_y),
        .rsp_valid     (rsp_valid),
        .rsp_y         (rsp_y),
        .issued_cnt    (issued_cnt),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] golden(input logic [7:0] x);
        real r;
        r = 65535.0 / (1.0 + $exp(-(real'($signed(x)) / 32.0)));
        return 16'(int'(r));
    endfunction

    // External sigmoid: L-cycle pipeline with its own state, untouched by rst_n.
    logic [L-1:0] sm_v = '0;
    logic [7:0]   sm_x [L] = '{default: 8'h00};
    logic         force_ov = 1'b0;

    always @(posedge clk) begin
        sm_v    <= {sm_v[L-2:0], sig_in_valid};
        sm_x[0] <= sig_x;
        for (int k = 1; k < L; k++) sm_x[k] <= sm_x[k-1];
    end
    assign sig_out_valid = sm_v[L-1] | force_ov;
    assign sig_y         = golden(sm_x[L-1]);

    typedef struct {
        int          cyc;
        int          id;
        logic [15:0] y;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] sx_q[$];
    int         grant_log[$];
    int         mptr = 0;
    int         mcnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference arbiter: scan from the pointer, first valid requester wins.
    always @(negedge clk or negedge rst_n) begin : model_p
        int g;
        if (!rst_n) begin
            mptr = 0;
            mcnt = 0;
            exp_q.delete();
            sx_q.delete();
        end else begin
            g = -1;
            if (!i_hold) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && req_valid[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
                end
            end
            chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : 32'(1 << g));
            if (g >= 0) begin
                exp_q.push_back('{cyc + L + 2, g, golden(req_x[g*8 +: 8])});
                sx_q.push_back(req_x[g*8 +: 8]);
                grant_log.push_back(g);
                mptr = (g + 1) % NREQ;
                mcnt++;
            end
        end
    end

    always @(negedge clk) begin : monitor_p
        exp_t e;
        if (rst_n) begin
            if (sig_in_valid) begin
                if (sx_q.size() == 0) chk("sig_in_valid_unexpected", 32'(sig_in_valid), 32'd0);
                else chk("sig_x", 32'(sig_x), 32'(sx_q.pop_front()));
            end
            if (rsp_valid != 0) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'(1 << e.id));
                    chk("rsp_y", 32'(rsp_y), 32'(e.y));
                    chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                chk("rsp_missing", 32'(rsp_valid), 32'(1 << e.id));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_log(input string name, input int want[$]);
        chk({name, "_len"}, 32'(grant_log.size()), 32'(want.size()));
        for (int i = 0; i < want.size() && i < grant_log.size(); i++) begin
            chk(name, 32'(grant_log[i]), 32'(want[i]));
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_sig_in_valid"}, 32'(sig_in_valid), 32'd0);
        chk({tag, "_sig_x"},        32'(sig_x),        32'd0);
        chk({tag, "_rsp_valid"},    32'(rsp_valid),    32'd0);
        chk({tag, "_rsp_y"},        32'(rsp_y),        32'd0);
        chk({tag, "_issued_cnt"},   32'(issued_cnt),   32'd0);
        chk({tag, "_o_err"},        32'(o_err),        32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int want[$];
        rst_n     = 1'b0;
        i_hold    = 1'b0;
        req_valid = '0;
        req_x     = '0;
        repeat (2) step();
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        // Sole requester 2 streams three operands.
        req_valid = 4'b0100;
        req_x[23:16] = 8'h00; step();
        req_x[23:16] = 8'h10; step();
        req_x[23:16] = 8'h80; step();
        req_valid = '0;
        repeat (8) step();
        chk("t1_issued_cnt", 32'(issued_cnt), 32'd3);
        want = '{2, 2, 2};
        chk_log("t1_grant", want);

        // Park pointer at 0, then all four requesters for eight cycles.
        req_valid = 4'b1000; step();
        grant_log.delete();
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            req_x = $urandom;
            step();
        end
        req_valid = '0;
        repeat (8) step();
        want = '{0, 1, 2, 3, 0, 1, 2, 3};
        chk_log("t2_grant", want);
        chk("t2_o_err", 32'(o_err), 32'd0);
        chk("t2_issued_cnt", 32'(issued_cnt), 32'd12);

        // Pointer at 2 with requesters 1 and 3 competing.
        req_valid = 4'b0010; step();
        grant_log.delete();
        req_valid = 4'b1010;
        repeat (3) step();
        req_valid = '0;
        repeat (8) step();
        want = '{3, 1, 3};
        chk_log("t3_grant", want);

        // Hold after two grants; in-flight results must still return.
        grant_log.delete();
        req_valid = 4'b1111;
        req_x = $urandom;
        repeat (2) step();
        i_hold = 1'b1;
        #1;
        chk("t4_hold_ready", 32'(req_ready), 32'd0);
        repeat (4) step();
        i_hold = 1'b0;
        step();
        req_valid = '0;
        repeat (8) step();
        want = '{0, 1, 2};
        chk_log("t4_grant", want);
        chk("t4_drained", 32'(exp_q.size()), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            req_valid = NREQ'($urandom);
            req_x     = $urandom;
            i_hold    = ($urandom_range(0, 7) == 0);
            step();
        end
        req_valid = '0;
        i_hold    = 1'b0;
        repeat (10) step();
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        chk("rand_o_err", 32'(o_err), 32'd0);
        chk("rand_issued_cnt", 32'(issued_cnt), 32'(16'(mcnt)));

        // Result strobe with nothing in flight.
        force_ov = 1'b1;
        step();
        force_ov = 1'b0;
        chk("t5_o_err", 32'(o_err), 32'd1);
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (5) step();
        chk("t5_o_err_sticky", 32'(o_err), 32'd1);

        // Reset with L operands inside the sigmoid.
        req_valid = 4'b1111;
        req_x = $urandom;
        repeat (3) step();
        req_valid = '0;
        step();
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("t6_midrst");
        #2;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
        end
        #1;
        chk("t6_o_err", 32'(o_err), 32'd1);
        chk("t6_issued_cnt", 32'(issued_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
